// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI burst RAM: FSM state enums, the
// read-return beat record and burst encodings.
package axi_ram_pkg;

  localparam int RAM_WIDTH  = 128;
  localparam int RAM_ID_LEN = 2;
  localparam int BEAT_BYTES = RAM_WIDTH / 8;

  // Only FIXED changes addressing; INCR, WRAP and the reserved code all advance.
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} WFsm_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} RFsm_t;

  typedef struct packed {
    logic [RAM_WIDTH-1:0]  data;
    logic [RAM_ID_LEN-1:0] id;
    logic                  last;
  } RBeat_t;

endpackage

// File: rtl/axi_ram_rfifo.sv
// Two-entry return FIFO for read beats; push and pop in the same cycle are
// allowed even when full.
module axi_ram_rfifo
  import axi_ram_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [$bits(RBeat_t)-1:0]  pushBeat_i,
  input  logic                       pop_i,
  output logic [$bits(RBeat_t)-1:0]  head_o,
  output logic [1:0]                 count_o
);

  RBeat_t     slot_q [2];
  logic       rdPtr_q;
  logic       wrPtr_q;
  logic [1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      rdPtr_q   <= 1'b0;
      wrPtr_q   <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push_i) begin
        slot_q[wrPtr_q] <= pushBeat_i;
        wrPtr_q         <= ~wrPtr_q;
      end
      if (pop_i) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = slot_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4-subset burst slave backed by a single-port synchronous SRAM; one write
// burst and one read burst run concurrently and share the port beat by beat.
module axi_burst_ram
  import axi_ram_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int ID_LEN   = 2,
  parameter int ADDR_LEN = 32,
  parameter int DEPTH_E  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_LEN-1:0]   s_axi_awid,
  input  logic [ADDR_LEN-1:0] s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [WIDTH-1:0]    s_axi_wdata,
  input  logic [WIDTH/8-1:0]  s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  input  logic                s_axi_bready,
  output logic [ID_LEN-1:0]   s_axi_bid,
  output logic                s_axi_bvalid,
  input  logic [ID_LEN-1:0]   s_axi_arid,
  input  logic [ADDR_LEN-1:0] s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  input  logic                s_axi_rready,
  output logic [ID_LEN-1:0]   s_axi_rid,
  output logic [WIDTH-1:0]    s_axi_rdata,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid
);

  localparam int NBYTES = WIDTH / 8;
  localparam logic [DEPTH_E-1:0] IDX_ONE = 1;

  WFsm_t               wState_q, wState_d;
  logic [ID_LEN-1:0]   wId_q, wId_d;
  logic [DEPTH_E-1:0]  wIdx_q, wIdx_d;
  logic [7:0]          wCnt_q, wCnt_d;
  logic                wFixed_q, wFixed_d;

  RFsm_t               rState_q, rState_d;
  logic [ID_LEN-1:0]   rId_q, rId_d;
  logic [DEPTH_E-1:0]  rIdx_q, rIdx_d;
  logic [7:0]          rCnt_q, rCnt_d;
  logic                rFixed_q, rFixed_d;

  logic                grantW_q, grantW_d;
  logic                inFlight_q;
  logic                inFlightLast_q;
  logic [ID_LEN-1:0]   inFlightId_q;
  logic [WIDTH-1:0]    memRdata_q;
  logic [WIDTH-1:0]    mem [2**DEPTH_E];

  logic                wReq, rIssuable, wGrant, rGrant, rPop;
  logic [2:0]          occAfterPop;
  logic [1:0]          fifoCount;
  RBeat_t              pushBeat, headBeat;

  // Counting this cycle's pop lets a new read issue every cycle under
  // continuous rready, so the R channel streams without bubbles.
  assign rPop        = s_axi_rvalid && s_axi_rready;
  assign occAfterPop = {1'b0, fifoCount} + {2'b00, inFlight_q} - {2'b00, rPop};
  assign rIssuable   = (rState_q == R_ISSUE) && (occAfterPop < 3'd2);
  assign wReq        = (wState_q == W_DATA) && s_axi_wvalid;

  assign s_axi_wready = (wState_q == W_DATA) && (!rIssuable || grantW_q);
  assign wGrant       = s_axi_wready && s_axi_wvalid;
  assign rGrant       = rIssuable && !wGrant;
  assign grantW_d     = (wReq && rIssuable) ? !wGrant : grantW_q;

  assign s_axi_awready = (wState_q == W_IDLE);
  assign s_axi_bvalid  = (wState_q == W_RESP);
  assign s_axi_bid     = wId_q;
  assign s_axi_arready = (rState_q == R_IDLE);

  always_comb begin
    wState_d = wState_q;
    wId_d    = wId_q;
    wIdx_d   = wIdx_q;
    wCnt_d   = wCnt_q;
    wFixed_d = wFixed_q;
    case (wState_q)
      W_IDLE: if (s_axi_awvalid) begin
        wId_d    = s_axi_awid;
        wIdx_d   = s_axi_awaddr[DEPTH_E+3:4];
        wCnt_d   = s_axi_awlen;
        wFixed_d = (s_axi_awburst == BURST_FIXED);
        wState_d = W_DATA;
      end
      W_DATA: if (wGrant) begin
        wIdx_d = wFixed_q ? wIdx_q : wIdx_q + IDX_ONE;
        wCnt_d = wCnt_q - 8'd1;
        if (wCnt_q == 8'd0) wState_d = W_RESP;
      end
      W_RESP: if (s_axi_bready) wState_d = W_IDLE;
      default: wState_d = W_IDLE;
    endcase
  end

  always_comb begin
    rState_d = rState_q;
    rId_d    = rId_q;
    rIdx_d   = rIdx_q;
    rCnt_d   = rCnt_q;
    rFixed_d = rFixed_q;
    case (rState_q)
      R_IDLE: if (s_axi_arvalid) begin
        rId_d    = s_axi_arid;
        rIdx_d   = s_axi_araddr[DEPTH_E+3:4];
        rCnt_d   = s_axi_arlen;
        rFixed_d = (s_axi_arburst == BURST_FIXED);
        rState_d = R_ISSUE;
      end
      R_ISSUE: if (rGrant) begin
        rIdx_d = rFixed_q ? rIdx_q : rIdx_q + IDX_ONE;
        rCnt_d = rCnt_q - 8'd1;
        if (rCnt_q == 8'd0) rState_d = R_DRAIN;
      end
      R_DRAIN: if (rPop && headBeat.last) rState_d = R_IDLE;
      default: rState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wState_q       <= W_IDLE;
      wId_q          <= '0;
      wIdx_q         <= '0;
      wCnt_q         <= '0;
      wFixed_q       <= 1'b0;
      rState_q       <= R_IDLE;
      rId_q          <= '0;
      rIdx_q         <= '0;
      rCnt_q         <= '0;
      rFixed_q       <= 1'b0;
      grantW_q       <= 1'b1;
      inFlight_q     <= 1'b0;
      inFlightLast_q <= 1'b0;
      inFlightId_q   <= '0;
    end else begin
      wState_q       <= wState_d;
      wId_q          <= wId_d;
      wIdx_q         <= wIdx_d;
      wCnt_q         <= wCnt_d;
      wFixed_q       <= wFixed_d;
      rState_q       <= rState_d;
      rId_q          <= rId_d;
      rIdx_q         <= rIdx_d;
      rCnt_q         <= rCnt_d;
      rFixed_q       <= rFixed_d;
      grantW_q       <= grantW_d;
      inFlight_q     <= rGrant;
      inFlightLast_q <= (rCnt_q == 8'd0);
      inFlightId_q   <= rId_q;
    end
  end

  // SRAM array: byte-masked write port and registered read, contents not reset.
  always_ff @(posedge clk) begin
    if (wGrant) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (s_axi_wstrb[b]) mem[wIdx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
    if (rGrant) memRdata_q <= mem[rIdx_q];
  end

  assign pushBeat = '{data: memRdata_q, id: inFlightId_q, last: inFlightLast_q};

  axi_ram_rfifo u_rfifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inFlight_q),
    .pushBeat_i (pushBeat),
    .pop_i      (rPop),
    .head_o     (headBeat),
    .count_o    (fifoCount)
  );

  assign s_axi_rvalid = (fifoCount != 2'd0);
  assign s_axi_rdata  = headBeat.data;
  assign s_axi_rid    = headBeat.id;
  assign s_axi_rlast  = headBeat.last;

  property wlastOnFinalBeat;
    @(posedge clk) disable iff (rst) wGrant |-> (s_axi_wlast == (wCnt_q == 8'd0));
  endproperty
  assert property (wlastOnFinalBeat);

  logic unused;
  assign unused = ^{s_axi_awaddr[ADDR_LEN-1:DEPTH_E+4], s_axi_awaddr[3:0], s_axi_awsize,
                    s_axi_awlock, s_axi_awcache, s_axi_araddr[ADDR_LEN-1:DEPTH_E+4],
                    s_axi_araddr[3:0], s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_wlast};

endmodule

// File: tb/tb_axi_burst_ram.sv
// Bench for axi_burst_ram: directed table, multi-cycle corner sequences and
// randomized bursts checked against an index-level memory model.
module tb_axi_burst_ram;

  localparam int WIDTH = 128, ID_LEN = 2, ADDR_LEN = 32, DEPTH_E = 16;
  localparam int NIDX  = 1 << DEPTH_E;

  logic clk = 1'b0;
  logic rst;
  logic [ID_LEN-1:0] awid, arid, bid, rid;
  logic [ADDR_LEN-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst;
  logic awlock, arlock, awvalid, awready, arvalid, arready;
  logic [3:0] awcache, arcache;
  logic [WIDTH-1:0] wdata, rdata;
  logic [WIDTH/8-1:0] wstrb;
  logic wlast, wvalid, wready, bready, bvalid, rready, rlast, rvalid;

  axi_burst_ram #(.WIDTH(WIDTH), .ID_LEN(ID_LEN), .ADDR_LEN(ADDR_LEN), .DEPTH_E(DEPTH_E)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bvalid(bvalid),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  // Reference model: memory as an array of beats indexed by beat number.
  logic [WIDTH-1:0] refMem [int];
  logic [WIDTH-1:0] wBeatData [$];
  logic [WIDTH/8-1:0] wBeatStrb [$];
  logic [WIDTH-1:0] rxData [$];
  logic [ID_LEN-1:0] rxId [$];
  logic rxLast [$];
  int unsigned wHs [$];
  int unsigned arStart, bDoneCyc, rLastCyc;
  int firstT, lastT;

  typedef struct {
    logic [ID_LEN-1:0]   wid;
    logic [31:0]         waddr;
    logic [WIDTH-1:0]    wdata;
    logic [WIDTH/8-1:0]  wstrb;
    logic [ID_LEN-1:0]   rid;
    logic [31:0]         raddr;
    logic [WIDTH-1:0]    expData;
  } Vec_t;
  Vec_t vecs [6];

  function automatic logic [WIDTH-1:0] refRead(input int idx);
    return refMem.exists(idx) ? refMem[idx] : '0;
  endfunction

  function automatic int nextIdx(input int idx, input logic [1:0] burst);
    return (burst == 2'b00) ? idx : (idx + 1) % NIDX;
  endfunction

  task automatic modelWrite(input int idx, input logic [WIDTH-1:0] d, input logic [WIDTH/8-1:0] s);
    logic [WIDTH-1:0] cur;
    cur = refRead(idx);
    for (int b = 0; b < WIDTH/8; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    refMem[idx] = cur;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " awready"}, awready, 1);
    checkOutput({tag, " arready"}, arready, 1);
    checkOutput({tag, " wready"}, wready, 0);
    checkOutput({tag, " bvalid"}, bvalid, 0);
    checkOutput({tag, " rvalid"}, rvalid, 0);
    checkOutput({tag, " rlast"}, rlast, 0);
    checkOutput({tag, " bid"}, bid, 0);
    checkOutput({tag, " rid"}, rid, 0);
    checkOutput({tag, " rdata"}, rdata, 0);
  endtask

  // Write burst from wBeatData/wBeatStrb; abortAfter >= 0 stops after that beat.
  task automatic applyStimulusWrite(input logic [ID_LEN-1:0] id, input logic [31:0] addr,
                                    input logic [7:0] len, input logic [1:0] burst,
                                    input int abortAfter);
    int idx;
    bit ok;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk); if (awready) ok = 1;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    checkOutput("aw handshake", ok, 1);
    idx = addr[DEPTH_E+3:4];
    for (int n = 0; n <= int'(len); n++) begin
      wdata = wBeatData[n]; wstrb = wBeatStrb[n]; wlast = (n == int'(len)); wvalid = 1'b1;
      ok = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
        @(negedge clk); if (wready) ok = 1;
        @(posedge clk); #1;
      end
      checkOutput("w handshake", ok, 1);
      wHs.push_back(cyc);
      modelWrite(idx, wBeatData[n], wBeatStrb[n]);
      idx = nextIdx(idx, burst);
      if (n == abortAfter) begin
        wvalid = 1'b0; wlast = 1'b0;
        return;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    checkOutput("bvalid one cycle after last W", bvalid, 1);
    bready = 1'b1;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (bvalid) begin
        ok = 1;
        checkOutput("bid", bid, id);
      end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    bDoneCyc = cyc;
    checkOutput("b handshake", ok, 1);
  endtask

  // Read burst; mode 0 = rready high, 1 = toggling 1010, 2 = random.
  task automatic applyStimulusRead(input logic [ID_LEN-1:0] id, input logic [31:0] addr,
                                   input logic [7:0] len, input logic [1:0] burst, input int mode);
    bit ok, stalled;
    int nb;
    logic [WIDTH-1:0] heldData;
    rxData.delete(); rxId.delete(); rxLast.delete();
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk); if (arready) ok = 1;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    arStart = cyc;
    checkOutput("ar handshake", ok, 1);
    nb = 0; stalled = 0; firstT = -1; lastT = -1; heldData = '0;
    for (int t = 0; t < 200 && nb <= int'(len); t++) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        checkOutput("rvalid held while stalled", rvalid, 1);
        checkOutput("rdata held while stalled", rdata, heldData);
      end
      stalled = rvalid && !rready;
      heldData = rdata;
      if (rvalid && rready) begin
        rxData.push_back(rdata); rxId.push_back(rid); rxLast.push_back(rlast);
        if (firstT < 0) firstT = t;
        lastT = t;
        nb++;
      end
      @(posedge clk); #1;
      if (rvalid === 1'b0 || nb > int'(len)) rLastCyc = cyc;
    end
    rready = 1'b0;
    rLastCyc = arStart + 32'(lastT) + 1;
    checkOutput("read beat count", nb, 32'(int'(len) + 1));
  endtask

  task automatic checkOutputRead(input string name, input logic [ID_LEN-1:0] id,
                                 input logic [31:0] addr, input logic [7:0] len,
                                 input logic [1:0] burst);
    int idx;
    idx = addr[DEPTH_E+3:4];
    for (int n = 0; n <= int'(len) && n < rxData.size(); n++) begin
      checkOutput({name, " rdata"}, rxData[n], refRead(idx));
      checkOutput({name, " rid"}, rxId[n], id);
      checkOutput({name, " rlast"}, rxLast[n], (n == int'(len)));
      idx = nextIdx(idx, burst);
    end
  endtask

  task automatic fillBeats(input int n, input logic [WIDTH-1:0] base, input logic [WIDTH/8-1:0] s);
    wBeatData.delete(); wBeatStrb.delete();
    for (int i = 0; i < n; i++) begin
      wBeatData.push_back(base * (i + 1));
      wBeatStrb.push_back(s);
    end
  endtask

  logic [WIDTH-1:0] ones;
  bit sawB;

  initial begin
    ones = {16{8'h11}};
    vecs[0] = '{2'd1, 32'h0000_0100, 128'h01234567_89ABCDEF_00000000_DEADBEEF, 16'hFFFF,
                2'd2, 32'h0000_0100, 128'h01234567_89ABCDEF_00000000_DEADBEEF};
    vecs[1] = '{2'd0, 32'h0010_0307, 128'h11112222_33334444_55556666_77778888, 16'hFFFF,
                2'd3, 32'h0000_030C, 128'h11112222_33334444_55556666_77778888};
    vecs[2] = '{2'd2, 32'h0000_0300, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 16'h00F0,
                2'd1, 32'h0000_0300, 128'h11112222_33334444_CCCCCCCC_77778888};
    vecs[3] = '{2'd3, 32'h0000_0300, {16{8'hFF}}, 16'h0000,
                2'd0, 32'h0000_0300, 128'h11112222_33334444_CCCCCCCC_77778888};
    vecs[4] = '{2'd1, 32'h0000_0300, 128'hEE000000_00000000_00000000_00000000, 16'h8000,
                2'd2, 32'h0000_0300, 128'hEE112222_33334444_CCCCCCCC_77778888};
    vecs[5] = '{2'd2, 32'h000F_FFF0, 128'hC0C0C0C0_12345678_9ABCDEF0_0F0F0F0F, 16'hFFFF,
                2'd3, 32'hFFFF_FFF0, 128'hC0C0C0C0_12345678_9ABCDEF0_0F0F0F0F};

    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd4; awburst = 2'b01; awlock = 0; awcache = '0;
    awvalid = 0; arid = '0; araddr = '0; arlen = '0; arsize = 3'd4; arburst = 2'b01; arlock = 0;
    arcache = '0; arvalid = 0; wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0; rready = 0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed single-beat table: write then read back with latency check.
    for (int i = 0; i < 6; i++) begin
      wBeatData = '{vecs[i].wdata}; wBeatStrb = '{vecs[i].wstrb};
      applyStimulusWrite(vecs[i].wid, vecs[i].waddr, 8'd0, 2'b01, -1);
      applyStimulusRead(vecs[i].rid, vecs[i].raddr, 8'd0, 2'b01, 0);
      if (rxData.size() > 0) begin
        checkOutput($sformatf("vec%0d rdata", i), rxData[0], vecs[i].expData);
        checkOutput($sformatf("vec%0d rid", i), rxId[0], vecs[i].rid);
        checkOutput($sformatf("vec%0d rlast", i), rxLast[0], 1);
      end
      checkOutput($sformatf("vec%0d AR to rvalid cycles", i), firstT, 2);
    end

    // Burst with strobes: beat 2 only updates bytes 3:0.
    fillBeats(4, {WIDTH{1'b1}}, 16'hFFFF);
    for (int i = 0; i < 4; i++) wBeatData[i] = {WIDTH{1'b1}};
    applyStimulusWrite(2'd0, 32'h200, 8'd3, 2'b01, -1);
    fillBeats(4, ones, 16'hFFFF);
    wBeatData[0] = '0;
    for (int i = 1; i < 4; i++) wBeatData[i] = ones * i;
    wBeatStrb[2] = 16'h000F;
    applyStimulusWrite(2'd1, 32'h200, 8'd3, 2'b01, -1);
    applyStimulusRead(2'd3, 32'h200, 8'd3, 2'b01, 0);
    checkOutputRead("strobe burst", 2'd3, 32'h200, 8'd3, 2'b01);
    if (rxData.size() == 4) checkOutput("strobe beat2 const", rxData[2], {{96{1'b1}}, 32'h22222222});
    checkOutput("zero-bubble span", lastT - firstT, 3);

    // Backpressure: 8-beat read with rready toggling.
    fillBeats(8, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 16'hFFFF);
    applyStimulusWrite(2'd2, 32'h1000, 8'd7, 2'b01, -1);
    applyStimulusRead(2'd1, 32'h1000, 8'd7, 2'b01, 1);
    checkOutputRead("backpressure", 2'd1, 32'h1000, 8'd7, 2'b01);

    // Contention: write and read launched in the same cycle.
    fillBeats(4, 128'h13579BDF_2468ACE0_FEDCBA98_76543210, 16'hFFFF);
    applyStimulusWrite(2'd0, 32'h3000, 8'd3, 2'b01, -1);
    fillBeats(4, 128'h0A0B0C0D_01020304_05060708_090A0B0C, 16'hFFFF);
    wHs.delete();
    fork
      applyStimulusWrite(2'd1, 32'h4000, 8'd3, 2'b01, -1);
      applyStimulusRead(2'd2, 32'h3000, 8'd3, 2'b01, 0);
    join
    checkOutputRead("contention read", 2'd2, 32'h3000, 8'd3, 2'b01);
    if (wHs.size() == 4) begin
      checkOutput("first W grant wins", wHs[0] - arStart, 1);
      for (int i = 1; i < 4; i++) checkOutput("W grant alternation", wHs[i] - wHs[i-1], 2);
    end
    checkOutput("contention done within 10", (bDoneCyc - arStart <= 10) && (rLastCyc - arStart <= 10), 1);
    applyStimulusRead(2'd0, 32'h4000, 8'd3, 2'b01, 0);
    checkOutputRead("contention write", 2'd0, 32'h4000, 8'd3, 2'b01);

    // INCR wrap from the top index, and FIXED burst.
    wBeatData = '{128'hAAAA0000, 128'hBBBB1111}; wBeatStrb = '{16'hFFFF, 16'hFFFF};
    applyStimulusWrite(2'd1, 32'h000F_FFF0, 8'd1, 2'b01, -1);
    applyStimulusRead(2'd1, 32'h0, 8'd0, 2'b01, 0);
    if (rxData.size() == 1) checkOutput("wrap beat1 at index 0", rxData[0], 128'hBBBB1111);
    wBeatData = '{128'h5050, 128'h6060}; wBeatStrb = '{16'hFFFF, 16'hFFFF};
    applyStimulusWrite(2'd2, 32'h400, 8'd1, 2'b01, -1);
    wBeatData = '{128'hF0, 128'hF1, 128'hF2}; wBeatStrb = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    applyStimulusWrite(2'd3, 32'h400, 8'd2, 2'b00, -1);
    applyStimulusRead(2'd0, 32'h400, 8'd1, 2'b01, 0);
    if (rxData.size() == 2) begin
      checkOutput("fixed keeps last beat", rxData[0], 128'hF2);
      checkOutput("fixed neighbour untouched", rxData[1], 128'h6060);
    end

    // Reset mid-burst after beat 1 of a 4-beat write.
    fillBeats(4, 128'h99, 16'hFFFF);
    applyStimulusWrite(2'd0, 32'h500, 8'd3, 2'b01, -1);
    fillBeats(4, 128'h7700_0000_0000_0000_0000_0000_0000_0042, 16'hFFFF);
    applyStimulusWrite(2'd1, 32'h500, 8'd3, 2'b01, 1);
    rst = 1'b1;
    #1;
    checkResetOutputs("async reset");
    @(negedge clk); rst = 1'b0;
    sawB = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk); if (bvalid) sawB = 1;
    end
    checkOutput("no B after reset", sawB, 0);
    @(posedge clk); #1;
    applyStimulusRead(2'd3, 32'h500, 8'd3, 2'b01, 0);
    checkOutputRead("after reset", 2'd3, 32'h500, 8'd3, 2'b01);

    // Randomized bursts checked against the model.
    for (int it = 0; it < 15; it++) begin
      logic [31:0] a;
      logic [7:0] len;
      logic [1:0] bt;
      logic [ID_LEN-1:0] id;
      a = $urandom; len = 8'($urandom_range(0, 7)); bt = 2'($urandom_range(0, 3));
      id = ID_LEN'($urandom);
      wBeatData.delete(); wBeatStrb.delete();
      for (int n = 0; n <= int'(len); n++) begin
        wBeatData.push_back({$urandom, $urandom, $urandom, $urandom});
        wBeatStrb.push_back(16'hFFFF);
      end
      applyStimulusWrite(id, a, len, bt, -1);
      for (int n = 0; n <= int'(len); n++) begin
        wBeatData[n] = {$urandom, $urandom, $urandom, $urandom};
        wBeatStrb[n] = 16'($urandom);
      end
      applyStimulusWrite(id + 1'b1, a, len, bt, -1);
      applyStimulusRead(id, a, len, bt, 2);
      checkOutputRead($sformatf("random%0d", it), id, a, len, bt);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
